// File: rtl/lsu_pkg.sv
// Shared types and size helpers for the load alignment path.
// Size codes follow the load funct3-style encoding used by the core.
package lsu_pkg;

  typedef enum logic [2:0] {
    SZ_LW  = 3'b000,
    SZ_LB  = 3'b001,
    SZ_LBU = 3'b010,
    SZ_LH  = 3'b011,
    SZ_LHU = 3'b100,
    SZ_LWU = 3'b101,
    SZ_LD  = 3'b110,
    SZ_ILL = 3'b111
  } load_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_CAP0,
    S_CAP1,
    S_RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input load_size_e sz);
    logic [3:0] n;
    case (sz)
      SZ_LB, SZ_LBU: n = 4'd1;
      SZ_LH, SZ_LHU: n = 4'd2;
      SZ_LW, SZ_LWU: n = 4'd4;
      SZ_LD:         n = 4'd8;
      default:       n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic size_legal(
    input load_size_e sz,
    input int         xlen
  );
    logic ok;
    case (sz)
      SZ_ILL:        ok = 1'b0;
      SZ_LWU, SZ_LD: ok = (xlen == 64);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane extraction and sign/zero extension.
// Takes a two-beat window so split loads reuse the same shifter.
module load_extract
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            beat0,
  input  logic [XLEN-1:0]            beat1,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  load_size_e                 size,
  output logic [XLEN-1:0]            res
);

  logic [XLEN-1:0] sh;

  assign sh = XLEN'({beat1, beat0} >> {off, 3'b000});

  always_comb begin
    res = '0;
    case (size)
      SZ_LB:   res = XLEN'($signed(sh[7:0]));
      SZ_LBU:  res = XLEN'(sh[7:0]);
      SZ_LH:   res = XLEN'($signed(sh[15:0]));
      SZ_LHU:  res = XLEN'(sh[15:0]);
      SZ_LW:   res = XLEN'($signed(sh[31:0]));
      SZ_LWU:  res = XLEN'(sh[31:0]);
      SZ_LD:   res = sh;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Multi-cycle load stage: word reads, split crossing loads, extend.
// One request in flight; memory returns data one cycle after rd_en.
module load_align_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AW          = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [2:0]      req_size,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  state_e state, state_nx;

  logic [AW-OB-1:0] word_q;
  load_size_e       size_q;
  logic [OB-1:0]    off_q;
  logic             cross_q;
  logic [XLEN-1:0]  beat0_q;

  load_size_e       req_sz;
  logic [OB:0]      span;
  logic             req_cross;
  logic             req_fault;
  logic             accept;

  logic [XLEN-1:0]  ext_b0;
  logic [XLEN-1:0]  ext_b1;
  logic [XLEN-1:0]  ext_res;

  assign req_sz    = load_size_e'(req_size);
  assign span      = {1'b0, req_addr[OB-1:0]}
                   + (OB+1)'(size_bytes(req_sz));
  assign req_cross = span > (OB+1)'(NB);
  assign req_fault = !size_legal(req_sz, XLEN)
                   || (req_cross && MISALIGN_EN == 0);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = req_fault ? S_RESP : S_RD0;
      S_RD0:  state_nx = S_CAP0;
      S_CAP0: state_nx = cross_q ? S_CAP1 : S_RESP;
      S_CAP1: state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    rsp_valid = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        state == S_IDLE: req_ready = 1'b1;
        state == S_RD0: begin
          mem_rd_en = 1'b1;
          mem_addr  = {word_q, {OB{1'b0}}};
        end
        state == S_CAP0 && cross_q: begin
          mem_rd_en = 1'b1;
          mem_addr  = {word_q + (AW-OB)'(1), {OB{1'b0}}};
        end
        state == S_RESP: rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // CAP1 sees beat1 on the bus; CAP0 extracts with an empty upper beat.
  assign ext_b0 = (state == S_CAP1) ? beat0_q   : mem_rdata;
  assign ext_b1 = (state == S_CAP1) ? mem_rdata : '0;

  load_extract #(.XLEN(XLEN)) u_extract (
    .beat0 (ext_b0),
    .beat1 (ext_b1),
    .off   (off_q),
    .size  (size_q),
    .res   (ext_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= '0;
      size_q    <= SZ_LW;
      off_q     <= '0;
      cross_q   <= 1'b0;
      beat0_q   <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      if (accept) begin
        word_q  <= req_addr[AW-1:OB];
        size_q  <= req_sz;
        off_q   <= req_addr[OB-1:0];
        cross_q <= req_cross;
        if (req_fault) begin
          rsp_data  <= '0;
          rsp_fault <= 1'b1;
        end
      end
      if (state == S_CAP0) beat0_q <= mem_rdata;
      if ((state == S_CAP0 && !cross_q) || state == S_CAP1) begin
        rsp_data  <= ext_res;
        rsp_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench: three configurations (32/split, 32/no-split, 64/split)
// share a byte-addressed memory model and stimulus bus.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [2:0]  vld;
  logic [2:0]  rdy, rd, rv, rf;
  logic [31:0] ma [3];
  logic [31:0] d0, d1, m0, m1;
  logic [63:0] d2, m2;
  logic [63:0] rdat [3];

  always #5 clk = ~clk;

  assign rdat[0] = {32'b0, d0};
  assign rdat[1] = {32'b0, d1};
  assign rdat[2] = d2;

  load_align_unit #(.XLEN(32), .AW(32), .MISALIGN_EN(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_addr(req_addr), .req_size(req_size), .mem_rd_en(rd[0]),
    .mem_addr(ma[0]), .mem_rdata(m0), .rsp_valid(rv[0]),
    .rsp_data(d0), .rsp_fault(rf[0])
  );

  load_align_unit #(.XLEN(32), .AW(32), .MISALIGN_EN(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_addr(req_addr), .req_size(req_size), .mem_rd_en(rd[1]),
    .mem_addr(ma[1]), .mem_rdata(m1), .rsp_valid(rv[1]),
    .rsp_data(d1), .rsp_fault(rf[1])
  );

  load_align_unit #(.XLEN(64), .AW(32), .MISALIGN_EN(1)) u_c (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_addr(req_addr), .req_size(req_size), .mem_rd_en(rd[2]),
    .mem_addr(ma[2]), .mem_rdata(m2), .rsp_valid(rv[2]),
    .rsp_data(d2), .rsp_fault(rf[2])
  );

  logic [7:0] mem [logic [31:0]];

  function automatic logic [63:0] rdw(input logic [31:0] a, input int nb);
    logic [63:0] w;
    logic [31:0] b;
    w = '0;
    for (int i = 0; i < nb; i++) begin
      b = a + 32'(i);
      if (mem.exists(b)) w[i*8 +: 8] = mem[b];
    end
    return w;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [63:0] w,
                    input int nb);
    for (int i = 0; i < nb; i++) mem[a + 32'(i)] = w[i*8 +: 8];
  endtask

  // Junk on non-read cycles so stale or late data would be visible.
  always @(posedge clk) begin
    m0 <= rd[0] ? 32'(rdw(ma[0], 4)) : 32'hA5A5_A5A5;
    m1 <= rd[1] ? 32'(rdw(ma[1], 4)) : 32'h5A5A_5A5A;
    m2 <= rd[2] ? rdw(ma[2], 8) : 64'hA5A5_5A5A_A5A5_5A5A;
  end

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t        expq  [3][$];
  logic [31:0] addrq [3][$];
  int          acc_n [3];
  int          ncyc   = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        mex;
  logic [31:0] mea;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i]) acc_n[i] = ncyc;
      if (rd[i]) begin
        checks++;
        if (addrq[i].size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected inst%0d addr=%h required no read",
                   i, ma[i]);
        end else begin
          mea = addrq[i].pop_front();
          if (ma[i] !== mea) begin
            errors++;
            $display("FAIL rd_addr inst%0d got=%h exp=%h", i, ma[i], mea);
          end
        end
      end else if (ma[i] !== 32'h0) begin
        checks++;
        errors++;
        $display("FAIL addr_idle inst%0d got=%h exp=0", i, ma[i]);
      end
      if (rv[i]) begin
        checks++;
        if (expq[i].size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected inst%0d data=%h", i, rdat[i]);
        end else begin
          mex = expq[i].pop_front();
          if (rdat[i] !== mex.data || rf[i] !== mex.fault ||
              ncyc - acc_n[i] != mex.lat) begin
            errors++;
            $display("FAIL rsp inst%0d got=%h/f%b/lat%0d exp=%h/f%b/lat%0d",
                     i, rdat[i], rf[i], ncyc - acc_n[i],
                     mex.data, mex.fault, mex.lat);
          end
        end
      end
    end
    ncyc++;
  end

  task automatic issue(input int inst, input logic [31:0] a,
                       input logic [2:0] sz, input logic [63:0] ed,
                       input logic ef, input int lat,
                       input logic [31:0] r0, input logic [31:0] r1,
                       input int nrd);
    exp_t ex;
    ex.data  = ed;
    ex.fault = ef;
    ex.lat   = lat;
    expq[inst].push_back(ex);
    if (nrd > 0) addrq[inst].push_back(r0);
    if (nrd > 1) addrq[inst].push_back(r1);
    req_addr  = a;
    req_size  = sz;
    vld[inst] = 1'b1;
    @(posedge clk);
    #1 vld[inst] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (expq[inst].size() != 0 || addrq[inst].size() != 0) begin
      errors++;
      $display("FAIL timeout inst%0d addr=%h pending rsp=%0d rd=%0d",
               inst, a, expq[inst].size(), addrq[inst].size());
      expq[inst].delete();
      addrq[inst].delete();
    end
    checks++;
    if (rdat[inst] !== ed || rf[inst] !== ef) begin
      errors++;
      $display("FAIL hold inst%0d got=%h/f%b exp=%h/f%b",
               inst, rdat[inst], rf[inst], ed, ef);
    end
  endtask

  initial begin
    reset    = 1'b1;
    vld      = 3'b000;
    req_addr = '0;
    req_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 3'b000 || rd !== 3'b000 || rv !== 3'b000) begin
      errors++;
      $display("FAIL in_reset rdy=%b rd=%b rv=%b exp=000", rdy, rd, rv);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 3'b111 || rf !== 3'b000 || d0 !== 0 || d1 !== 0 ||
        d2 !== 0) begin
      errors++;
      $display("FAIL post_reset rdy=%b rf=%b d0=%h d1=%h d2=%h", rdy, rf,
               d0, d1, d2);
    end
    @(posedge clk);
    #1;

    wr(32'h100, 64'hDEADBEEF, 4);
    issue(0, 32'h100, 3'b000, 64'hDEADBEEF, 0, 3, 32'h100, 0, 1);
    wr(32'h100, 64'h80FF1234, 4);
    issue(0, 32'h103, 3'b001, 64'hFFFFFF80, 0, 3, 32'h100, 0, 1);
    issue(0, 32'h103, 3'b010, 64'h00000080, 0, 3, 32'h100, 0, 1);
    issue(0, 32'h102, 3'b011, 64'hFFFF80FF, 0, 3, 32'h100, 0, 1);
    issue(0, 32'h101, 3'b100, 64'h0000FF12, 0, 3, 32'h100, 0, 1);

    wr(32'h100, 64'hAABBCCDD, 4);
    wr(32'h104, 64'h11223344, 4);
    issue(0, 32'h102, 3'b000, 64'h3344AABB, 0, 4, 32'h100, 32'h104, 2);
    issue(0, 32'h103, 3'b011, 64'h000044AA, 0, 4, 32'h100, 32'h104, 2);
    issue(0, 32'h100, 3'b110, 64'h0, 1, 1, 0, 0, 0);
    issue(0, 32'h100, 3'b101, 64'h0, 1, 1, 0, 0, 0);
    issue(0, 32'h100, 3'b111, 64'h0, 1, 1, 0, 0, 0);

    wr(32'hFFFFFFFC, 64'h55667788, 4);
    wr(32'h0, 64'h99AABBCC, 4);
    issue(0, 32'hFFFFFFFE, 3'b000, 64'hBBCC5566, 0, 4,
          32'hFFFFFFFC, 32'h0, 2);

    addrq[0].push_back(32'h100);
    req_addr = 32'h100;
    req_size = 3'b000;
    vld[0]   = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset got=%b exp=0", rdy[0]);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=1", rdy[0]);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (addrq[0].size() != 0) begin
      errors++;
      $display("FAIL reset_drop pending rd=%0d exp=0", addrq[0].size());
      addrq[0].delete();
    end
    issue(0, 32'h100, 3'b000, 64'hAABBCCDD, 0, 3, 32'h100, 0, 1);

    issue(1, 32'h102, 3'b000, 64'h0, 1, 1, 0, 0, 0);
    issue(1, 32'h100, 3'b000, 64'hAABBCCDD, 0, 3, 32'h100, 0, 1);
    issue(1, 32'h101, 3'b011, 64'hFFFFBBCC, 0, 3, 32'h100, 0, 1);
    issue(1, 32'h103, 3'b100, 64'h0, 1, 1, 0, 0, 0);

    wr(32'h8, 64'h0123456789ABCDEF, 8);
    wr(32'h10, 64'h000000000000BEEF, 8);
    issue(2, 32'h8, 3'b110, 64'h0123456789ABCDEF, 0, 3, 32'h8, 0, 1);
    issue(2, 32'hC, 3'b000, 64'h0000000001234567, 0, 3, 32'h8, 0, 1);
    issue(2, 32'h8, 3'b000, 64'hFFFFFFFF89ABCDEF, 0, 3, 32'h8, 0, 1);
    issue(2, 32'h8, 3'b101, 64'h0000000089ABCDEF, 0, 3, 32'h8, 0, 1);
    issue(2, 32'hE, 3'b011, 64'h0000000000000123, 0, 3, 32'h8, 0, 1);
    issue(2, 32'hE, 3'b000, 64'hFFFFFFFFBEEF0123, 0, 4,
          32'h8, 32'h10, 2);
    issue(2, 32'h8, 3'b111, 64'h0, 1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
